// File: rtl/psum_mux_arb.sv
// psum_mux_arb: shares one PSUM accumulation buffer between NUM_MAC MAC units.
//
// A round-robin arbiter picks one requesting MAC per cycle and returns a one-cycle
// one-hot Rdy pulse. The winner's {addr, psum} then goes through a two-stage
// read-add-write pipeline into the buffer. A back-to-back update of the same
// address takes its base from the previous write instead of the stale read data.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   I_Start, I_AccEn  start a row pass; AccEn picks accumulate (1) or overwrite (0)
//   I_Val/I_Addr/I_Psum/I_Empty   per-MAC request handshake and idle flags
//   O_Rdy             registered one-hot grant pulse
//   O_RdEn/O_RdAddr, I_RdData     buffer read port (data one cycle after enable)
//   O_WrEn/O_WrAddr/O_WrData      buffer write port
//   O_Busy, O_Done    pass in progress, one-cycle completion pulse
module psum_mux_arb #(
    parameter int unsigned NUM_MAC    = 16,
    parameter int unsigned PSUM_WIDTH = 24,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          I_Start,
    input  logic                          I_AccEn,
    input  logic [NUM_MAC-1:0]            I_Val,
    input  logic [NUM_MAC*ADDR_WIDTH-1:0] I_Addr,
    input  logic [NUM_MAC*PSUM_WIDTH-1:0] I_Psum,
    input  logic [NUM_MAC-1:0]            I_Empty,
    output logic [NUM_MAC-1:0]            O_Rdy,
    output logic                          O_RdEn,
    output logic [ADDR_WIDTH-1:0]         O_RdAddr,
    input  logic [PSUM_WIDTH-1:0]         I_RdData,
    output logic                          O_WrEn,
    output logic [ADDR_WIDTH-1:0]         O_WrAddr,
    output logic [PSUM_WIDTH-1:0]         O_WrData,
    output logic                          O_Busy,
    output logic                          O_Done
);

    localparam int unsigned IdxW = (NUM_MAC > 1) ? $clog2(NUM_MAC) : 1;
    localparam int unsigned SumW = IdxW + 1;

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    state_e                  state_q;
    logic                    acc_en_q;
    logic [1:0]              ign_q;
    logic [IdxW-1:0]         rr_q;
    logic [NUM_MAC-1:0]      rdy_q;

    logic                    s1_v_q;
    logic [ADDR_WIDTH-1:0]   s1_addr_q;
    logic [PSUM_WIDTH-1:0]   s1_psum_q;
    logic                    s2_v_q;
    logic [ADDR_WIDTH-1:0]   s2_addr_q;
    logic [PSUM_WIDTH-1:0]   s2_psum_q;

    // Copy of the previous cycle's write, used as the forwarding source.
    logic                    fwd_v_q;
    logic [ADDR_WIDTH-1:0]   fwd_addr_q;
    logic [PSUM_WIDTH-1:0]   fwd_sum_q;

    logic [NUM_MAC-1:0]      elig;
    logic                    gnt_v;
    logic [IdxW-1:0]         gnt_idx;
    logic [IdxW-1:0]         scan_idx;
    logic [SumW-1:0]         scan_sum;
    logic [PSUM_WIDTH-1:0]   base;
    logic [PSUM_WIDTH-1:0]   wr_sum;
    logic                    run_over;

    // The MAC holding Rdy this cycle may still show Val, so it sits out one round.
    assign elig = I_Val & ~rdy_q;

    always_comb begin
        gnt_v    = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        scan_sum = '0;
        for (int k = 0; k < int'(NUM_MAC); k++) begin
            scan_sum = {1'b0, rr_q} + SumW'(k);
            if (scan_sum >= SumW'(NUM_MAC)) begin
                scan_sum = scan_sum - SumW'(NUM_MAC);
            end
            scan_idx = scan_sum[IdxW-1:0];
            if (!gnt_v && elig[scan_idx]) begin
                gnt_v   = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        if (state_q != StRun) begin
            gnt_v = 1'b0;
        end
    end

    // The prior write is still in flight to the buffer, so the read data would be stale.
    always_comb begin
        base = '0;
        if (acc_en_q) begin
            if (fwd_v_q && (fwd_addr_q == s2_addr_q)) begin
                base = fwd_sum_q;
            end else begin
                base = I_RdData;
            end
        end
        wr_sum = s2_psum_q + base;
    end

    assign run_over = (ign_q == 2'd0) && (&I_Empty) && !(|I_Val) && !(|rdy_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            acc_en_q   <= 1'b0;
            ign_q      <= 2'd0;
            rr_q       <= '0;
            rdy_q      <= '0;
            s1_v_q     <= 1'b0;
            s1_addr_q  <= '0;
            s1_psum_q  <= '0;
            s2_v_q     <= 1'b0;
            s2_addr_q  <= '0;
            s2_psum_q  <= '0;
            fwd_v_q    <= 1'b0;
            fwd_addr_q <= '0;
            fwd_sum_q  <= '0;
        end else begin
            rdy_q  <= '0;
            s1_v_q <= gnt_v;
            if (gnt_v) begin
                rdy_q[gnt_idx] <= 1'b1;
                s1_addr_q      <= I_Addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                s1_psum_q      <= I_Psum[gnt_idx*PSUM_WIDTH +: PSUM_WIDTH];
                if (gnt_idx == IdxW'(NUM_MAC - 1)) begin
                    rr_q <= '0;
                end else begin
                    rr_q <= gnt_idx + 1'b1;
                end
            end

            s2_v_q    <= s1_v_q;
            s2_addr_q <= s1_addr_q;
            s2_psum_q <= s1_psum_q;

            fwd_v_q    <= s2_v_q;
            fwd_addr_q <= s2_addr_q;
            fwd_sum_q  <= wr_sum;

            unique case (state_q)
                StIdle: begin
                    if (I_Start) begin
                        state_q  <= StRun;
                        acc_en_q <= I_AccEn;
                        // MAC Empty flags are unreliable right after their reset.
                        ign_q    <= 2'd2;
                    end
                end
                StRun: begin
                    if (ign_q != 2'd0) begin
                        ign_q <= ign_q - 2'd1;
                    end else if (run_over) begin
                        state_q <= StFlush;
                    end
                end
                StFlush: begin
                    if (!s1_v_q && !s2_v_q) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign O_Rdy    = rdy_q;
    assign O_RdEn   = s1_v_q;
    assign O_RdAddr = s1_addr_q;
    assign O_WrEn   = s2_v_q;
    assign O_WrAddr = s2_addr_q;
    assign O_WrData = s2_v_q ? wr_sum : '0;
    assign O_Busy   = (state_q != StIdle);
    // High in the FLUSH cycle that returns to IDLE.
    assign O_Done   = (state_q == StFlush) && !s1_v_q && !s2_v_q;

endmodule

// File: tb/tb_psum_mux_arb.sv
// Scoreboard bench for psum_mux_arb: a reference model computes grant order and
// buffer contents per pass; a monitor process pops and compares DUT activity.
module tb_psum_mux_arb;

    localparam int N  = 16;
    localparam int PW = 24;
    localparam int AW = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [PW-1:0] data;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            I_Start;
    logic            I_AccEn;
    logic [N-1:0]    I_Val;
    logic [N*AW-1:0] I_Addr;
    logic [N*PW-1:0] I_Psum;
    logic [N-1:0]    I_Empty;
    logic [N-1:0]    O_Rdy;
    logic            O_RdEn;
    logic [AW-1:0]   O_RdAddr;
    logic [PW-1:0]   I_RdData;
    logic            O_WrEn;
    logic [AW-1:0]   O_WrAddr;
    logic [PW-1:0]   O_WrData;
    logic            O_Busy;
    logic            O_Done;

    always #5 clk = ~clk;

    psum_mux_arb #(
        .NUM_MAC   (N),
        .PSUM_WIDTH(PW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .I_Start (I_Start),
        .I_AccEn (I_AccEn),
        .I_Val   (I_Val),
        .I_Addr  (I_Addr),
        .I_Psum  (I_Psum),
        .I_Empty (I_Empty),
        .O_Rdy   (O_Rdy),
        .O_RdEn  (O_RdEn),
        .O_RdAddr(O_RdAddr),
        .I_RdData(I_RdData),
        .O_WrEn  (O_WrEn),
        .O_WrAddr(O_WrAddr),
        .O_WrData(O_WrData),
        .O_Busy  (O_Busy),
        .O_Done  (O_Done)
    );

    // Buffer: synchronous read returns old data when read and write collide.
    logic [PW-1:0] ram [N];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [PW-1:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (O_WrEn) ram[O_WrAddr] <= O_WrData;
        if (O_RdEn) I_RdData <= ram[O_RdAddr];
    end

    int  errs = 0;
    int  checks = 0;
    int  cyc = 0;
    int  done_cnt = 0;
    int  done_cyc = 0;
    int  last_wr_cyc = 0;
    bit  mon_en = 1'b0;
    bit  prev_done = 1'b0;

    logic [PW-1:0] mem [N];
    int            model_ptr = 0;
    int            exp_gnt [$];
    wr_t           exp_wr [$];
    int            rdy_cyc [$];
    logic [AW-1:0] w_addr [N];
    logic [PW-1:0] w_psum [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        int  m;
        int  rc;
        wr_t w;
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_done) check("busy_after_done", 32'(O_Busy), 32'd0);
            prev_done = O_Done;
            if (O_Done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (mon_en) begin
                if (O_Rdy != '0) begin
                    if (exp_gnt.size() == 0) begin
                        check("grant_unexpected", 32'(O_Rdy), 32'd0);
                    end else begin
                        m = exp_gnt.pop_front();
                        check("grant", 32'(O_Rdy), 32'd1 << m);
                    end
                    rdy_cyc.push_back(cyc);
                end
                if (O_WrEn) begin
                    if (exp_wr.size() == 0) begin
                        check("write_unexpected", 32'(O_WrEn), 32'd0);
                    end else begin
                        w = exp_wr.pop_front();
                        check("wr_addr", 32'(O_WrAddr), 32'(w.addr));
                        check("wr_data", 32'(O_WrData), 32'(w.data));
                    end
                    if (rdy_cyc.size() != 0) begin
                        rc = rdy_cyc.pop_front();
                        check("wr_latency", 32'(cyc - rc), 32'd1);
                    end
                    last_wr_cyc = cyc;
                end
            end
            // MAC side: Val drops in the cycle Rdy is seen.
            I_Val = I_Val & ~O_Rdy;
        end
    endtask

    task automatic preload(input int a, input logic [PW-1:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a[AW-1:0];
        pl_data = d;
        mem[a]  = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic start_pass(input bit acc);
        @(negedge clk);
        I_Start = 1'b1;
        I_AccEn = acc;
        I_Empty = '0;
        @(negedge clk);
        I_Start = 1'b0;
        #1;
        check("busy_run", 32'(O_Busy), 32'd1);
    endtask

    // One pass: every MAC in mask raises one request together, then all go empty.
    task automatic run_pass(input bit acc, input logic [N-1:0] mask, input bit stray);
        int            i;
        int            last;
        int            d0;
        int            nreq;
        int            wave_cyc;
        logic [PW-1:0] v;
        wr_t           w;
        start_pass(acc);
        last = -1;
        nreq = 0;
        for (int k = 0; k < N; k++) begin
            i = (model_ptr + k) % N;
            if (mask[i]) begin
                exp_gnt.push_back(i);
                v = acc ? mem[w_addr[i]] + w_psum[i] : w_psum[i];
                mem[w_addr[i]] = v;
                w.addr = w_addr[i];
                w.data = v;
                exp_wr.push_back(w);
                last = i;
                nreq++;
            end
        end
        if (last >= 0) model_ptr = (last + 1) % N;
        for (int j = 0; j < N; j++) begin
            I_Addr[j*AW +: AW] = w_addr[j];
            I_Psum[j*PW +: PW] = w_psum[j];
        end
        d0      = done_cnt;
        I_Val   = mask;
        I_Empty = '1;
        if (stray) begin
            I_Start = 1'b1;
            I_AccEn = ~acc;
        end
        #1;
        wave_cyc = cyc;
        @(negedge clk);
        I_Start = 1'b0;
        #1;
        for (int t = 0; t < 100 && done_cnt == d0; t++) begin
            @(negedge clk);
            #1;
        end
        check("done_seen", 32'(done_cnt - d0), 32'd1);
        check("done_after_last_write", 32'(done_cyc - last_wr_cyc), 32'd1);
        check("pass_length", 32'(done_cyc - wave_cyc), 32'(nreq + 2));
        check("grants_left", 32'(exp_gnt.size()), 32'd0);
        check("writes_left", 32'(exp_wr.size()), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        I_Start = 1'b0;
        I_AccEn = 1'b0;
        I_Val   = '0;
        I_Addr  = '0;
        I_Psum  = '0;
        I_Empty = '0;
        pl_en   = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        fork
            monitor();
        join_none
        repeat (2) @(negedge clk);
        #1;
        check("rst_rdy", 32'(O_Rdy), 32'd0);
        check("rst_rden", 32'(O_RdEn), 32'd0);
        check("rst_wren", 32'(O_WrEn), 32'd0);
        check("rst_wrdata", 32'(O_WrData), 32'd0);
        check("rst_done", 32'(O_Done), 32'd0);
        check("rst_busy", 32'(O_Busy), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        for (int a = 0; a < N; a++) preload(a, PW'($urandom));

        // All MACs at once from pointer 0: grants 0..15, pointer back to 0.
        for (int j = 0; j < N; j++) begin
            w_addr[j] = AW'(j);
            w_psum[j] = PW'(j + 1);
        end
        run_pass(1'b1, '1, 1'b0);

        // Same-address back-to-back: 100+5=105, then 105-3=102.
        preload(2, PW'(100));
        w_addr[0] = 4'd2;
        w_psum[0] = PW'(5);
        w_addr[1] = 4'd2;
        w_psum[1] = 24'hFFFFFD;
        run_pass(1'b1, 16'h0003, 1'b0);

        // Single request: MAC5 addr 3 psum 7 onto 10.
        preload(3, PW'(10));
        w_addr[5] = 4'd3;
        w_psum[5] = PW'(7);
        run_pass(1'b1, 16'h0020, 1'b0);

        // Overwrite mode.
        preload(4, PW'(50));
        w_addr[9] = 4'd4;
        w_psum[9] = PW'(9);
        run_pass(1'b0, 16'h0200, 1'b0);

        // Modular wrap.
        preload(7, 24'h7FFFFF);
        w_addr[12] = 4'd7;
        w_psum[12] = PW'(1);
        run_pass(1'b1, 16'h1000, 1'b0);

        for (int r = 0; r < 40; r++) begin
            for (int j = 0; j < N; j++) begin
                w_addr[j] = AW'($urandom_range(N - 1));
                w_psum[j] = PW'($urandom);
            end
            run_pass(1'($urandom_range(1)),
                     N'($urandom) | (N'(1) << $urandom_range(N - 1)),
                     ($urandom_range(3) == 0));
        end

        // Reset in the middle of a busy pass.
        mon_en = 1'b0;
        start_pass(1'b1);
        for (int j = 0; j < N; j++) begin
            I_Addr[j*AW +: AW] = AW'(j);
            I_Psum[j*PW +: PW] = PW'(j);
        end
        I_Val = '1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_rdy", 32'(O_Rdy), 32'd0);
        check("midrst_wren", 32'(O_WrEn), 32'd0);
        check("midrst_rden", 32'(O_RdEn), 32'd0);
        check("midrst_done", 32'(O_Done), 32'd0);
        check("midrst_busy", 32'(O_Busy), 32'd0);
        rst     = 1'b0;
        I_Val   = '0;
        I_Empty = '1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            #1;
            check("post_rst_quiet", {15'd0, O_Rdy, O_WrEn, O_Done}, 32'd0);
        end
        exp_gnt.delete();
        exp_wr.delete();
        rdy_cyc.delete();
        model_ptr = 0;
        mon_en    = 1'b1;
        for (int a = 0; a < N; a++) preload(a, PW'($urandom));
        for (int j = 0; j < N; j++) begin
            w_addr[j] = AW'($urandom_range(N - 1));
            w_psum[j] = PW'($urandom);
        end
        run_pass(1'b1, 16'h8421, 1'b0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/psum_mux_arb.md
Name: psum_mux_arb

Overview:
- Shares one PSUM accumulation buffer between NUM_MAC MAC units in a PE block.
- Round-robin arbitrates the per-MAC Val/Addr/Psum handshakes and returns a one-cycle Rdy pulse to the granted MAC.
- Runs each winner through a read-add-write pipeline into the buffer, with forwarding for back-to-back same-address updates.
- Signals completion when every MAC is empty and the pipeline has drained.

Parameters:
NUM_MAC, 16, number of MAC requesters
PSUM_WIDTH, 24, partial-sum width (two's complement)
ADDR_WIDTH, 4, PSUM buffer address width (per-MAC Addr width)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
I_Start  in  1  pulse; begins a row pass (asserted together with the MACs' ARBMAC_Rst)
I_AccEn  in  1  sampled at I_Start; 1=accumulate into buffer, 0=overwrite
I_Val  in  NUM_MAC  per-MAC psum valid (level; drops the cycle Rdy is seen)
I_Addr  in  NUM_MAC*ADDR_WIDTH  packed per-MAC psum address, MAC i at [i*ADDR_WIDTH +: ADDR_WIDTH]
I_Psum  in  NUM_MAC*PSUM_WIDTH  packed per-MAC psum
I_Empty  in  NUM_MAC  per-MAC idle/empty flag
O_Rdy  out  NUM_MAC  registered one-hot grant pulse
O_RdEn  out  1  buffer read enable
O_RdAddr  out  ADDR_WIDTH  buffer read address
I_RdData  in  PSUM_WIDTH  buffer read data, valid 1 cycle after O_RdEn
O_WrEn  out  1  buffer write enable
O_WrAddr  out  ADDR_WIDTH  buffer write address
O_WrData  out  PSUM_WIDTH  buffer write data
O_Busy  out  1  high outside IDLE
O_Done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset (rst high at posedge): FSM=IDLE, rr pointer=0, all pipeline valids=0, all outputs 0. Reset mid-pass aborts with no further buffer writes and no O_Done.
- FSM states:
  - IDLE -> RUN on I_Start; latch I_AccEn; load 2-cycle empty-ignore counter.
  - RUN -> FLUSH when ignore counter=0, I_Empty all 1s, I_Val all 0s, no grant pending.
  - FLUSH -> IDLE when S1 and S2 are both invalid; O_Done=1 on that transition cycle.
  - I_Start outside IDLE is ignored.
- S0 (arbitrate, RUN only):
  - Eligible set = I_Val & ~O_Rdy; the just-granted MAC is masked for one cycle.
  - Winner = first eligible index at or after the rr pointer, wrapping from NUM_MAC-1 to 0.
  - Next cycle: O_Rdy[winner]=1 and S1 captures {addr, psum} of the winner from the grant-decision cycle.
  - rr pointer becomes winner+1 mod NUM_MAC.
  - At most one grant per cycle. No grants in IDLE or FLUSH.
- S1 (read): O_RdEn=S1.val, O_RdAddr=S1.addr. Advances to S2 every cycle; no stalls.
- S2 (write): O_WrEn=S2.val, O_WrAddr=S2.addr.
  - O_WrData = S2.psum + base, wrapping modulo 2^PSUM_WIDTH with no saturation.
  - base = 0 if AccEn=0.
  - Else base = the previous S2 sum if that write targeted the same address in the prior cycle (forward); else I_RdData.
- Latency: Val-high decision cycle t; O_Rdy at t+1; buffer read at t+1; write at t+2.
- Throughput: 1 psum/cycle sustained across different MACs. A single MAC is never granted on consecutive cycles.
- Simultaneous events: I_Start in the cycle of O_Done is ignored; it must arrive in IDLE.
- Out-of-range addresses (at or above the buffer depth) pass through unchecked; the MAC guarantees range.

Test Plan:
- Single request: I_Start, AccEn=1, buffer[3]=10, MAC5 Val with Addr=3, Psum=7 -> O_Rdy=0x0020 one cycle later; read addr 3; write addr 3 data 17 two cycles after grant.
- All 16 MACs raise Val together, pointer=0 -> grants 0,1,...,15 on consecutive cycles, each Rdy one-hot for exactly 1 cycle; pointer ends at 0.
- Hazard: MAC0 then MAC1 both Addr=2, Psum=5 and -3, back-to-back grants, buffer[2]=100 -> writes 105 then 102 (forwarded, not 97).
- AccEn=0: buffer[4]=50, Psum=9 at addr 4 -> write data 9.
- Wrap: PSUM_WIDTH=24, base=0x7FFFFF, Psum=1 -> write 0x800000.
- Completion: all I_Empty=1 and no Val after the last grant -> O_Done exactly 1 cycle after the final write, O_Busy low next cycle.
- Reset mid-pass: rst during RUN -> O_Rdy, O_WrEn and O_Done stay 0; IDLE next cycle.
